// File: rtl/fsm_dwell_timer.sv
// fsm_dwell_timer
// Per-state dwell timer for the FSM datapath. A prescaler divides the system
// clock into seconds. A saturating seconds counter then measures how long the
// FSM has been in its current non-idle state. Both counters clear whenever the
// FSM commits to a new state. A pause input freezes counting. A programmable
// timeout raises a one-cycle pulse and a sticky flag when the seconds count
// reaches the limit.
// Modes: IDLE (hold), RUN, PAUSE (hold) and CLEAR (state change).
// The timer state is the registers alone; there is no internal FSM.

module fsm_dwell_timer #(
    parameter int STATE_W   = 4,
    parameter int IDLE_CODE = 0,
    parameter int TICKS     = 50_000_000,
    parameter int SEC_W     = 8,
    parameter int T_W       = $clog2(TICKS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] state_next,
    input  logic [STATE_W-1:0] state_reg,
    input  logic               pause,
    input  logic [SEC_W-1:0]   limit,
    output logic [T_W-1:0]     t,
    output logic [SEC_W-1:0]   sec_t,
    output logic               tick,
    output logic               expire_pulse,
    output logic               expired
);

    // Encoded constants, sized to the counters they are compared against
    localparam logic [T_W-1:0]     T_LAST    = T_W'(TICKS - 1);
    localparam logic [T_W-1:0]     T_ZERO    = {T_W{1'b0}};
    localparam logic [T_W-1:0]     T_ONE     = T_W'(1'b1);
    localparam logic [SEC_W-1:0]   SEC_ZERO  = {SEC_W{1'b0}};
    localparam logic [SEC_W-1:0]   SEC_ONE   = SEC_W'(1'b1);
    localparam logic [SEC_W-1:0]   SEC_MAX   = {SEC_W{1'b1}};
    localparam logic [STATE_W-1:0] IDLE_ENC  = STATE_W'(IDLE_CODE);

    // Registered state; every output is driven straight from one of these
    logic [T_W-1:0]   t_r;
    logic [SEC_W-1:0] sec_t_r;
    logic             tick_r;
    logic             expire_pulse_r;
    logic             expired_r;

    // Next-state values computed combinationally
    logic [T_W-1:0]   t_nxt_s;
    logic [SEC_W-1:0] sec_t_nxt_s;
    logic             tick_nxt_s;
    logic             expire_pulse_nxt_s;
    logic             expired_nxt_s;

    // Decoded conditions
    logic             change_s;
    logic             active_s;
    logic             wrap_s;
    logic             sec_sat_s;
    logic [SEC_W-1:0] sec_inc_s;
    logic             hit_s;

    // Decode the per-edge conditions from the FSM inputs and counter state
    always_comb begin
        change_s  = (state_reg != state_next);
        active_s  = (state_reg != IDLE_ENC) && !pause;
        wrap_s    = (t_r == T_LAST);
        sec_sat_s = (sec_t_r == SEC_MAX);
        sec_inc_s = sec_t_r + SEC_ONE;
        // The limit only matters at the moment the seconds count steps onto it.
        // A saturated counter does not step, so it never re-fires the timeout.
        hit_s     = !sec_sat_s && (limit != SEC_ZERO) && (sec_inc_s == limit);
    end

    // Next-state logic in priority order: clear, hold, count, wrap
    always_comb begin
        t_nxt_s            = t_r;
        sec_t_nxt_s        = sec_t_r;
        tick_nxt_s         = 1'b0;
        expire_pulse_nxt_s = 1'b0;
        expired_nxt_s      = expired_r;
        if (change_s) begin
            // A new state commits: the dwell clock starts again from zero,
            // even in idle or while paused. A wrap on this edge is dropped.
            t_nxt_s            = T_ZERO;
            sec_t_nxt_s        = SEC_ZERO;
            tick_nxt_s         = 1'b0;
            expire_pulse_nxt_s = 1'b0;
            expired_nxt_s      = 1'b0;
        end else if (!active_s) begin
            // Idle or paused: the counters and the sticky flag hold
            t_nxt_s            = t_r;
            sec_t_nxt_s        = sec_t_r;
            tick_nxt_s         = 1'b0;
            expire_pulse_nxt_s = 1'b0;
            expired_nxt_s      = expired_r;
        end else if (!wrap_s) begin
            t_nxt_s            = t_r + T_ONE;
            sec_t_nxt_s        = sec_t_r;
            tick_nxt_s         = 1'b0;
            expire_pulse_nxt_s = 1'b0;
            expired_nxt_s      = expired_r;
        end else begin
            // The prescaler wraps: one second has elapsed
            t_nxt_s    = T_ZERO;
            tick_nxt_s = 1'b1;
            if (sec_sat_s) begin
                sec_t_nxt_s = sec_t_r;
            end else begin
                sec_t_nxt_s = sec_inc_s;
            end
            if (hit_s) begin
                expire_pulse_nxt_s = 1'b1;
                expired_nxt_s      = 1'b1;
            end else begin
                expire_pulse_nxt_s = 1'b0;
                expired_nxt_s      = expired_r;
            end
        end
    end

    // Timer registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_r            <= T_ZERO;
            sec_t_r        <= SEC_ZERO;
            tick_r         <= 1'b0;
            expire_pulse_r <= 1'b0;
            expired_r      <= 1'b0;
        end else begin
            t_r            <= t_nxt_s;
            sec_t_r        <= sec_t_nxt_s;
            tick_r         <= tick_nxt_s;
            expire_pulse_r <= expire_pulse_nxt_s;
            expired_r      <= expired_nxt_s;
        end
    end

    assign t            = t_r;
    assign sec_t        = sec_t_r;
    assign tick         = tick_r;
    assign expire_pulse = expire_pulse_r;
    assign expired      = expired_r;

endmodule

// File: tb/tb_fsm_dwell_timer.sv
// Testbench for fsm_dwell_timer (TICKS=4, SEC_W=3).
// The reference model counts active edges since the last clear. Outputs are
// derived from that count with division and modulo arithmetic.

module tb_fsm_dwell_timer;

    localparam int TICKS = 4;
    localparam int SEC_W = 3;
    localparam int SMAX  = 7;

    logic       clk;
    logic       rst;
    logic [3:0] state_next;
    logic [3:0] state_reg;
    logic       pause;
    logic [2:0] limit;
    logic [1:0] t;
    logic [2:0] sec_t;
    logic       tick;
    logic       expire_pulse;
    logic       expired;

    int errors;
    int checks;

    // Reference model state
    int cnt_m;
    int tick_m;
    int ep_m;
    int exp_m;

    fsm_dwell_timer #(
        .STATE_W  (4),
        .IDLE_CODE(0),
        .TICKS    (TICKS),
        .SEC_W    (SEC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .state_next  (state_next),
        .state_reg   (state_reg),
        .pause       (pause),
        .limit       (limit),
        .t           (t),
        .sec_t       (sec_t),
        .tick        (tick),
        .expire_pulse(expire_pulse),
        .expired     (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sec_of(input int c);
        int s;
        s = c / TICKS;
        if (s > SMAX) s = SMAX;
        return s;
    endfunction

    function automatic logic [7:0] model_vec();
        logic [1:0] mt;
        logic [2:0] ms;
        mt = 2'(cnt_m % TICKS);
        ms = 3'(sec_of(cnt_m));
        return {mt, ms, tick_m[0], ep_m[0], exp_m[0]};
    endfunction

    task automatic model_reset();
        cnt_m  = 0;
        tick_m = 0;
        ep_m   = 0;
        exp_m  = 0;
    endtask

    // One clock edge: advance the model with the inputs the DUT sees, then settle
    task automatic edge_step();
        int old_s;
        int new_s;
        @(posedge clk);
        if (state_reg != state_next) begin
            cnt_m = 0; tick_m = 0; ep_m = 0; exp_m = 0;
        end else if (state_reg == 4'd0 || pause) begin
            tick_m = 0; ep_m = 0;
        end else begin
            old_s = sec_of(cnt_m);
            cnt_m = cnt_m + 1;
            tick_m = 0; ep_m = 0;
            if (cnt_m % TICKS == 0) begin
                tick_m = 1;
                new_s = sec_of(cnt_m);
                if (old_s < SMAX && limit != 3'd0 && new_s == int'(limit)) begin
                    ep_m = 1;
                    exp_m = 1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // Present a one-edge state change to s, then settle in s
    task automatic enter_state(input logic [3:0] s);
        state_next = s;
        edge_step();
        state_reg = s;
    endtask

    task automatic test_reset();
        state_next = 4'd1; state_reg = 4'd1; pause = 1'b0; limit = 3'd0;
        rst = 1'b1;
        #7;
        checks++;
        if ({t, sec_t, tick, expire_pulse, expired} !== 8'h00) begin
            errors++;
            $display("FAIL reset: got %h expected 00", {t, sec_t, tick, expire_pulse, expired});
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_saturate();
        int ticks_seen;
        ticks_seen = 0;
        enter_state(4'd1);
        limit = 3'd0;
        for (int i = 0; i < 40; i++) begin
            edge_step();
            if (tick) ticks_seen++;
            checks++;
            if ({t, sec_t, tick, expire_pulse, expired} !== model_vec()) begin
                errors++;
                $display("FAIL saturate[%0d]: got %h expected %h", i,
                         {t, sec_t, tick, expire_pulse, expired}, model_vec());
            end
        end
        checks++;
        if (sec_t !== 3'd7 || expired !== 1'b0 || ticks_seen != 10) begin
            errors++;
            $display("FAIL saturate_end: sec=%0d exp=%0d ticks=%0d expected 7 0 10",
                     sec_t, expired, ticks_seen);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        int pulse_at;
        pulses = 0; pulse_at = -1;
        limit = 3'd3;
        enter_state(4'd5);
        for (int i = 1; i <= 20; i++) begin
            edge_step();
            if (expire_pulse) begin
                pulses++;
                pulse_at = i;
            end
            checks++;
            if ({t, sec_t, tick, expire_pulse, expired} !== model_vec()) begin
                errors++;
                $display("FAIL timeout[%0d]: got %h expected %h", i,
                         {t, sec_t, tick, expire_pulse, expired}, model_vec());
            end
        end
        checks++;
        if (pulses != 1 || pulse_at != 12 || expired !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: count=%0d at=%0d exp=%0d expected 1 12 1",
                     pulses, pulse_at, expired);
        end
        state_next = 4'd2;
        edge_step();
        checks++;
        if ({t, sec_t, expired} !== 6'd0) begin
            errors++;
            $display("FAIL timeout_clear: t=%0d sec=%0d exp=%0d expected 0 0 0", t, sec_t, expired);
        end
        state_reg = 4'd2;
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        state_reg = 4'd0; state_next = 4'd0; limit = 3'd0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            edge_step();
            if (t !== 2'd0 || sec_t !== 3'd0 || tick !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_hold: %0d bad cycles, expected 0", bad);
        end
        enter_state(4'd2);
        for (int i = 0; i < 6; i++) begin
            edge_step();
            checks++;
            if ({t, sec_t, tick, expire_pulse, expired} !== model_vec()) begin
                errors++;
                $display("FAIL idle_start[%0d]: got %h expected %h", i,
                         {t, sec_t, tick, expire_pulse, expired}, model_vec());
            end
        end
    endtask

    task automatic test_pause();
        int bad;
        int first_tick;
        bad = 0; first_tick = -1;
        enter_state(4'd3);
        edge_step();
        edge_step();
        checks++;
        if (t !== 2'd2) begin
            errors++;
            $display("FAIL pause_setup: t=%0d expected 2", t);
        end
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            edge_step();
            if (t !== 2'd2 || sec_t !== 3'd0 || tick !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pause_hold: %0d bad cycles, expected 0", bad);
        end
        pause = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            edge_step();
            if (tick && first_tick < 0) first_tick = i;
        end
        checks++;
        if (first_tick != 2) begin
            errors++;
            $display("FAIL pause_resume: first tick at %0d expected 2", first_tick);
        end
    endtask

    task automatic test_change_on_wrap();
        enter_state(4'd4);
        for (int i = 0; i < 7; i++) edge_step();
        checks++;
        if (t !== 2'd3) begin
            errors++;
            $display("FAIL wrap_setup: t=%0d expected 3", t);
        end
        state_next = 4'd6;
        edge_step();
        checks++;
        if (tick !== 1'b0 || sec_t !== 3'd0 || t !== 2'd0) begin
            errors++;
            $display("FAIL change_on_wrap: tick=%0d sec=%0d t=%0d expected 0 0 0", tick, sec_t, t);
        end
        state_reg = 4'd6;
    endtask

    task automatic test_rst_async();
        limit = 3'd5;
        enter_state(4'd7);
        for (int i = 0; i < 21; i++) edge_step();
        checks++;
        if (sec_t !== 3'd5 || expired !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: sec=%0d exp=%0d expected 5 1", sec_t, expired);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({t, sec_t, tick, expire_pulse, expired} !== 8'h00) begin
            errors++;
            $display("FAIL rst_async: got %h expected 00", {t, sec_t, tick, expire_pulse, expired});
        end
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) state_next = 4'($urandom_range(0, 3));
            else state_next = state_reg;
            pause = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0) limit = 3'($urandom_range(0, 7));
            edge_step();
            checks++;
            if ({t, sec_t, tick, expire_pulse, expired} !== model_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i,
                         {t, sec_t, tick, expire_pulse, expired}, model_vec());
            end
            state_reg = state_next;
        end
        pause = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        state_next = 4'd0; state_reg = 4'd0; pause = 1'b0; limit = 3'd0;
        model_reset();
        test_reset();
        test_saturate();
        test_timeout();
        test_idle();
        test_pause();
        test_change_on_wrap();
        test_rst_async();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsm_dwell_timer.md
# fsm_dwell_timer

Parametrised per-state dwell timer for the FSM datapath, successor to the fixed-size state timer. Clears whenever the FSM commits to a new state, prescales the system clock into seconds, and counts seconds spent in the current non-idle state. Adds pause, saturating seconds, a per-second tick and a programmable timeout with sticky flag, so the FSM can compare against `limit` instead of decoding `sec_t`.

## Interface
- `STATE_W`, 4, width of state encoding
- `IDLE_CODE`, 0, state encoding in which counting is suppressed
- `TICKS`, 50_000_000, clock cycles per second (≥2)
- `SEC_W`, 8, seconds counter width
- `T_W`, $clog2(TICKS), prescaler width (derived, not overridden)

- `clk` in 1 system clock, rising edge
- `rst` in 1 asynchronous, active-high reset
- `state_next` in STATE_W next state from FSM
- `state_reg` in STATE_W current state from state register
- `pause` in 1 hold all counters while high
- `limit` in SEC_W timeout in seconds; 0 disables timeout
- `t` out T_W prescaler count, 0..TICKS-1
- `sec_t` out SEC_W seconds in current state, saturating
- `tick` out 1 one-cycle pulse on each prescaler wrap
- `expire_pulse` out 1 one-cycle pulse when `sec_t` reaches `limit`
- `expired` out 1 sticky timeout flag

## Operation
- All outputs registered; reset value of `t`, `sec_t`, `tick`, `expire_pulse`, `expired` is 0.
- Per-edge priority (highest first):
  1. `change` = (`state_reg` != `state_next`): `t`←0, `sec_t`←0, `expired`←0, `tick`←0, `expire_pulse`←0. Applies even in IDLE or with `pause` high.
  2. `active` = (`state_reg` != IDLE_CODE) && !`pause`; if not active: `t`, `sec_t`, `expired` hold; `tick`, `expire_pulse`←0.
  3. Active, `t` < TICKS-1: `t`←`t`+1; pulses←0.
  4. Active, `t` == TICKS-1 (wrap): `t`←0, `tick`←1; `sec_t`←`sec_t`+1 unless `sec_t` == 2^SEC_W-1 (saturate, hold).
- Timeout: on a wrap edge where the incremented value equals `limit` and `limit` != 0, `expire_pulse`←1 and `expired`←1 on the same edge `sec_t` takes that value. `expired` stays 1 until `change` or `rst`.
- Saturation: `t` keeps wrapping and `tick` keeps pulsing once `sec_t` is saturated; no further `expire_pulse`.
- `limit` is sampled only on wrap edges; lowering `limit` below current `sec_t` never fires or clears `expired`.
- No counting state beyond the registers: the block has no internal FSM. Modes are IDLE (hold), RUN, PAUSE (hold) and CLEAR (change).

## Timing
- After a clearing edge, with no pause and non-idle state, first `tick` and `sec_t`=1 appear exactly TICKS edges later; `sec_t`=N after N·TICKS edges.
- `pause` takes effect on the edge where it is sampled high; counting resumes from held `t`, with no lost or extra cycles.
- `change` on the same edge as a wrap: clear wins, with no `tick` and no `expire_pulse`.
- `rst` asserted mid-count: all outputs 0 immediately (asynchronous). Counting restarts on the first active edge after deassertion.
- `tick`/`expire_pulse` never wider than one cycle; `expired` rises coincident with `expire_pulse`.

## Test plan
- TICKS=4, SEC_W=3, state_reg=state_next=1, limit=0: `tick` every 4 cycles; `sec_t` counts 1..7 and holds at 7; `expired` stays 0.
- Same setup with limit=3: `expire_pulse` high for one cycle at the 12th active edge along with `sec_t`=3; `expired` stays 1 until `state_next`=2 is presented, then `sec_t`, `t`, `expired` are all 0 on the next edge.
- state_reg=IDLE_CODE=state_next for 20 cycles after reset: `t`=`sec_t`=0 with no `tick`. Then present `state_next`=2 for one cycle followed by `state_reg`=2: counting starts from 0.
- Pause at `t`=2 for 10 cycles: `t`=2 and `sec_t` hold with no `tick`; first `tick` arrives 2 active cycles after release.
- `state_next` != `state_reg` on the same edge as `t`=3 wrap: `tick`=0, `sec_t`=0, `t`=0.
- `rst` pulsed asynchronously between edges with `sec_t`=5 and `expired`=1: all outputs read 0 before the next edge.
